mux4_rr_arbiter: RTL

- Shares one 4:1 data mux and a single registered output channel among four requesters.
- Uses round-robin arbitration with a bounded burst length.
- Drives the mux select, captures the selected input into an output register, and returns a one-hot grant to the winning requester.
- Uses a valid/ready handshake toward the downstream consumer, so the channel stalls cleanly under backpressure.

---
 rtl/mux4_rr_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter sharing one 4:1 mux and a registered
// valid/ready output channel. Each owner may hold the channel for at most
// MAX_BURST consecutive captures while other requesters are waiting.
module mux4_rr_arbiter #(
    parameter int unsigned DW        = 3,
    parameter int unsigned MAX_BURST = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    input  logic [DW-1:0] din2,
    input  logic [DW-1:0] din3,
    input  logic          out_ready,
    output logic [3:0]    grant,
    output logic [1:0]    sel,
    output logic [DW-1:0] dout,
    output logic          dout_valid
);

    localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

    typedef enum logic {StIdle, StBusy} state_t;

    state_t        state;
    logic [3:0]    burst_cnt;
    logic          free;
    logic          cap;
    logic          cont;
    logic [1:0]    pick;
    logic [DW-1:0] din_sel;

    assign free = !dout_valid || out_ready;
    assign cap  = free && (req != 4'b0000);
    // The current owner keeps the slot only while it is within its burst budget.
    assign cont = (state == StBusy) && req[sel] && (burst_cnt < MaxBurst);

    // Winner selection: continue the burst, else scan sel+1..sel+4 (owner last).
    always_comb begin
        logic       found;
        logic [1:0] idx;
        pick  = sel;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = sel + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        if (cont) begin
            pick = sel;
        end
    end

    // One-hot grant; forced low while reset is asserted.
    always_comb begin
        grant = 4'b0000;
        if (cap && rst_n) begin
            grant[pick] = 1'b1;
        end
    end

    // Data mux driven by the winner.
    always_comb begin
        din_sel = din0;
        unique case (pick)
            2'd0: din_sel = din0;
            2'd1: din_sel = din1;
            2'd2: din_sel = din2;
            2'd3: din_sel = din3;
            default: din_sel = din0;
        endcase
    end

    // Owner/burst FSM and output register; a stall (free=0) holds everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            burst_cnt  <= 4'd0;
            sel        <= 2'd3;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (cap) begin
            state      <= StBusy;
            // A wrap-around return to a lone owner restarts its burst count.
            burst_cnt  <= cont ? burst_cnt + 4'd1 : 4'd1;
            sel        <= pick;
            dout       <= din_sel;
            dout_valid <= 1'b1;
        end else if (free) begin
            state      <= StIdle;
            burst_cnt  <= 4'd0;
            dout_valid <= 1'b0;
        end
    end

endmodule
